// File: rtl/mat_stream_sequencer.sv
// Streams elementwise matrix operands into a lane-parallel ALU and drains results via a credit FIFO.
// Optional MAT_SEQ_PERF_EN adds busy/stall performance counters.
module mat_stream_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] A_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] B_BASE   = 16'h4000,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE = 16'h8000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [DIM_WIDTH-1:0]        cmd_dim1,
    input  logic [DIM_WIDTH-1:0]        cmd_dim2,
    input  logic [DATA_WIDTH-1:0]       cmd_scalar,
    output logic                        rd_en_a,
    output logic                        rd_en_b,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [ADDR_WIDTH-1:0]       rd_addr_a,
    output logic [ADDR_WIDTH-1:0]       rd_addr_b,
    input  logic [DATA_WIDTH*LANES-1:0] rd_data_a,
    input  logic [DATA_WIDTH*LANES-1:0] rd_data_b,
    output logic                        alu_valid,
    output logic [2:0]                  alu_op,
    output logic [DATA_WIDTH*LANES-1:0] alu_a,
    output logic [DATA_WIDTH*LANES-1:0] alu_b,
    input  logic                        res_valid,
    input  logic [DATA_WIDTH*LANES-1:0] res_data,
    output logic                        wr_en,
    input  logic                        wr_ready,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH*LANES-1:0] wr_data,
    output logic [LANES-1:0]            wr_mask,
    output logic                        busy,
    output logic                        done,
    output logic                        err
`ifdef MAT_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_cycles,
    output logic [31:0]                 perf_stall
`endif
);
    localparam int WW = DATA_WIDTH * LANES;
    localparam int EW = 2 * DIM_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(LANES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_d;

    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] scalar;
    logic [EW-1:0]         words, issued, written;
    logic [LW-1:0]         tail;
    logic [CW-1:0]         credits, count, inflight;
    logic [PW-1:0]         wp, rp;
    logic [WW-1:0]         fifo [FIFO_DEPTH];
    logic                  alu_v, err_q;

    logic [EW-1:0]         elems, words_c;
    logic [LW-1:0]         tail_c;
    logic                  accept, legal, issue, pop, push, last;
    logic [ADDR_WIDTH-1:0] rd_off;

    assign elems   = {{DIM_WIDTH{1'b0}}, cmd_dim1} * {{DIM_WIDTH{1'b0}}, cmd_dim2};
    assign words_c = elems / EW'(LANES) + EW'(elems % EW'(LANES) != '0);
    assign tail_c  = LW'(elems % EW'(LANES));
    assign accept  = cmd_valid && cmd_ready;
    assign legal   = cmd_op <= 3'd4;
    assign issue   = (state == ISSUE) && (credits != '0) && (issued < words);
    assign pop     = wr_en && wr_ready;
    // Words issued but not yet returned by the ALU.
    assign inflight = CW'(FIFO_DEPTH) - credits - count;
    assign push    = res_valid && (inflight != '0);
    assign last    = written == words - EW'(1);
    assign rd_off  = issued[ADDR_WIDTH-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (accept && legal) state_d = (words_c == '0) ? DONE : ISSUE;
            ISSUE: if (issued == words) state_d = DRAIN;
            DRAIN: if (written == words) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op      <= '0;
            scalar  <= '0;
            words   <= '0;
            tail    <= '0;
            issued  <= '0;
            written <= '0;
            credits <= CW'(FIFO_DEPTH);
            count   <= '0;
            wp      <= '0;
            rp      <= '0;
            alu_v   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            alu_v <= issue;
            if (accept) begin
                op      <= cmd_op;
                scalar  <= cmd_scalar;
                words   <= legal ? words_c : '0;
                tail    <= tail_c;
                issued  <= '0;
                written <= '0;
            end else begin
                if (issue) issued  <= issued + EW'(1);
                if (pop)   written <= written + EW'(1);
            end
            credits <= credits - CW'(issue) + CW'(pop);
            count   <= count + CW'(push) - CW'(pop);
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo[wp] <= res_data;
    end

    // A result with nothing outstanding is a protocol error and is dropped.
    always @(posedge clock) begin
        if (reset_n) assert (!(res_valid && inflight == '0));
    end

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign err       = err_q;
    assign rd_en_a   = issue;
    assign rd_en_b   = issue && (op == 3'd0);
    assign rd_addr   = issue ? rd_off : '0;
    assign rd_addr_a = issue ? A_BASE + rd_off : '0;
    assign rd_addr_b = rd_en_b ? B_BASE + rd_off : '0;
    assign alu_valid = alu_v;
    assign alu_op    = op;
    assign alu_a     = alu_v ? rd_data_a : '0;
    assign alu_b     = !alu_v ? '0 :
                       (op == 3'd0) ? rd_data_b : {LANES{scalar}};
    assign wr_en     = count != '0;
    assign wr_addr   = wr_en ? RES_BASE + written[ADDR_WIDTH-1:0] : '0;
    assign wr_data   = wr_en ? fifo[rp] : '0;
    assign wr_mask   = !wr_en ? '0 :
                       (last && tail != '0) ? ~({LANES{1'b1}} << tail) : '1;

`ifdef MAT_SEQ_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
            if ((state == ISSUE) && ((credits == '0) || (wr_en && !wr_ready))
                && !(&perf_stall))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
